// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter for two writers sharing one D-latch bank.
// Define LATCH_READBACK_EN to add a VERIFY state and the sticky err flag.
module latch_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Rb,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] lat_q,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy
`ifdef LATCH_READBACK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GATE,
`ifdef LATCH_READBACK_EN
    HOLD,
    VERIFY
`else
    HOLD
`endif
  } state_t;

  state_t state;
  logic   last;
  logic   pick;

  // Tie goes to whoever was not granted last.
  assign pick = req[1] & (~req[0] | ~last);

  always_ff @(posedge clk or negedge Rb) begin
    if (!Rb) begin
      state  <= IDLE;
      gnt    <= 2'b00;
      done   <= 2'b00;
      lat_en <= 1'b0;
      lat_d  <= '0;
      busy   <= 1'b0;
      last   <= 1'b1;
`ifdef LATCH_READBACK_EN
      err    <= 1'b0;
`endif
    end else begin
      done   <= 2'b00;
      lat_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state <= SETUP;
            busy  <= 1'b1;
            gnt   <= pick ? 2'b10 : 2'b01;
            lat_d <= pick ? din1 : din0;
            last  <= pick;
          end
        end
        SETUP: begin
          state  <= GATE;
          lat_en <= 1'b1;
        end
        GATE: begin
          state <= HOLD;
`ifndef LATCH_READBACK_EN
          done  <= gnt;
`endif
        end
`ifdef LATCH_READBACK_EN
        HOLD: begin
          state <= VERIFY;
          done  <= gnt;
          if (lat_q != lat_d) err <= 1'b1;
        end
        VERIFY: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
`else
        HOLD: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the latch data width.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Rb  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  2  write request per requester; bit i belongs to requester i.
REQ-005 din0  input  WIDTH  write data, requester 0.
REQ-006 din1  input  WIDTH  write data, requester 1.
REQ-007 lat_q  input  WIDTH  readback from the shared D-latch bank.
REQ-008 gnt  output  2  one-hot grant; held for the whole transaction.
REQ-009 done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 lat_d  output  WIDTH  data to the latch bank D inputs.
REQ-011 lat_en  output  1  latch gate; latch is transparent while high.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  sticky readback-mismatch flag; present only with the REQ-026 macro.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, GATE and HOLD, plus VERIFY when the REQ-026 macro is defined; all outputs SHALL be registered.
REQ-015 IDLE: if any req bit is high at an edge, the FSM SHALL go to SETUP, set gnt to the winner and load lat_d from that winner's din; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin; with both requests high, the requester not granted last SHALL win; a lone request SHALL always win.
REQ-017 SETUP -> GATE unconditionally; lat_en SHALL be high only in GATE, for exactly one cycle.
REQ-018 GATE -> HOLD; lat_d SHALL remain stable from SETUP through HOLD (data setup and hold around the gate).
REQ-019 HOLD (macro off): done[winner] SHALL pulse for one cycle; the FSM SHALL return to IDLE and clear gnt on the next edge.
REQ-020 Timing with the macro off: req seen at edge k -> gnt and lat_d valid at k+1, lat_en at k+2, done at k+3, IDLE at k+4; back-to-back writes therefore take 4 cycles each.
REQ-021 Once a transaction is granted, it SHALL complete even if req drops; later changes to din SHALL be ignored.
REQ-022 A req still high in IDLE after done SHALL start a new transaction; round-robin SHALL then favour the other requester if it is requesting.
REQ-023 busy SHALL equal (state != IDLE); gnt SHALL be zero exactly when busy is low.

Reset
REQ-024 While Rb is low: state = IDLE, gnt = 0, done = 0, lat_en = 0, lat_d = 0, busy = 0, err = 0, and the last-grant pointer = 1, so requester 0 wins the first tie.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction immediately; no done pulse SHALL be issued, and lat_en SHALL drop asynchronously.

Configuration
REQ-026 With macro LATCH_READBACK_EN defined: HOLD -> VERIFY; VERIFY compares lat_q with lat_d, pulses done, sets err on a mismatch (err stays set until reset), then returns to IDLE; transaction length is 5 cycles.
REQ-027 Without LATCH_READBACK_EN: there is no VERIFY state and no err port, and REQ-020 timing applies.

Verification
REQ-028 Reset, then req=01, din0=8'hA5 -> gnt=01 at k+1, lat_en high only at k+2, lat_d=8'hA5 k+1..k+3, done=01 at k+3.
REQ-029 req=11 held continuously from reset -> grants alternate 01,10,01,10; each done pulses once per grant.
REQ-030 req=10 for one cycle only, din1 changed to 8'h00 at k+2 -> transaction completes, lat_d stays at the original din1, done=10 at k+3.
REQ-031 Rb pulsed low during GATE -> lat_en, gnt and busy drop immediately; no done; the next request is granted to requester 0.
REQ-032 LATCH_READBACK_EN defined, lat_q forced to 8'h00 while writing 8'h3C -> done at k+4, err=1 and stays 1 through later matching writes until Rb is low.
